// File: rtl/des_frame_assembler.sv
// Collects a 17-byte UART frame (command, 8 key bytes, 8 data bytes) and
// presents it to a DES core as a single job with a valid/ready handshake.
module des_frame_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        des_ready,
    output logic        des_start,
    output logic        des_decrypt,
    output logic [63:0] des_key,
    output logic [63:0] des_block,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        DATA,
        ISSUE
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  byte_cnt;
    logic [31:0] tmo_cnt;
    logic        cmd_ok;

    assign cmd_ok = (rx_data == 8'h45) || (rx_data == 8'h44);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            des_start   <= 1'b0;
            des_decrypt <= 1'b0;
            des_key     <= '0;
            des_block   <= '0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (cmd_ok) begin
                            des_decrypt <= (rx_data == 8'h44);
                            byte_cnt    <= '0;
                            tmo_cnt     <= '0;
                            state       <= KEY;
                            busy        <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                KEY, DATA: begin
                    // A byte on the limit cycle wins over the timeout.
                    if (rx_valid) begin
                        tmo_cnt  <= '0;
                        byte_cnt <= byte_cnt + 3'd1;
                        if (state == KEY) begin
                            des_key <= {des_key[55:0], rx_data};
                        end else begin
                            des_block <= {des_block[55:0], rx_data};
                        end
                        if (byte_cnt == 3'd7) begin
                            if (state == KEY) begin
                                state <= DATA;
                            end else begin
                                state     <= ISSUE;
                                des_start <= 1'b1;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        busy      <= 1'b0;
                        byte_cnt  <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                ISSUE: begin
                    if (rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (des_start && des_ready) begin
                        des_start <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    des_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_des_frame_assembler.sv
// Randomized and directed bench for des_frame_assembler against a frame-level
// reference model kept in the bench.
module tb_des_frame_assembler;

    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        des_ready;
    logic        des_start;
    logic        des_decrypt;
    logic [63:0] des_key;
    logic [63:0] des_block;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    des_frame_assembler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .des_ready  (des_ready),
        .des_start  (des_start),
        .des_decrypt(des_decrypt),
        .des_key    (des_key),
        .des_block  (des_block),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: frame bytes collected in an array, idle gap counted
    // directly; stepped on each falling edge with the inputs the DUT just sampled.
    int          m_n    = 0;
    int          m_idle = 0;
    logic [7:0]  m_fr [17];
    bit          m_issue = 0, m_start = 0, m_ferr = 0, m_ovr = 0, m_dec = 0;
    logic [63:0] m_key = '0, m_blk = '0;

    int  start_cycles = 0, xfers = 0, ferr_pulses = 0, ovr_pulses = 0;
    bit  prev_start = 0, prev_ferr = 0, prev_ovr = 0;

    always @(negedge clk) begin
        if (reset) begin
            m_n = 0; m_idle = 0; m_issue = 0; m_start = 0;
            m_ferr = 0; m_ovr = 0; m_dec = 0;
        end else begin
            m_ferr = 0;
            m_ovr  = 0;
            if (m_issue) begin
                if (rx_valid) m_ovr = 1;
                if (des_ready) begin
                    m_issue = 0; m_start = 0; m_n = 0;
                end
            end else if (m_n == 0) begin
                if (rx_valid) begin
                    if (rx_data == 8'h45 || rx_data == 8'h44) begin
                        m_dec = (rx_data == 8'h44);
                        m_fr[0] = rx_data;
                        m_n = 1;
                        m_idle = 0;
                    end else begin
                        m_ferr = 1;
                    end
                end
            end else if (rx_valid) begin
                m_fr[m_n] = rx_data;
                m_n++;
                m_idle = 0;
                if (m_n == 17) begin
                    m_issue = 1;
                    m_start = 1;
                    for (int i = 0; i < 8; i++) begin
                        m_key[63 - 8*i -: 8] = m_fr[1 + i];
                        m_blk[63 - 8*i -: 8] = m_fr[9 + i];
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_ferr = 1;
                    m_n = 0;
                end
            end
        end

        check("busy", busy, (m_n != 0 || m_issue) ? 1 : 0);
        check("des_start", des_start, m_start);
        check("frame_err", frame_err, m_ferr);
        check("overrun", overrun, m_ovr);
        if (m_start) begin
            check("des_key", des_key, m_key);
            check("des_block", des_block, m_blk);
            check("des_decrypt", des_decrypt, m_dec);
        end
        check("frame_err_len", frame_err & prev_ferr, 0);
        check("overrun_len", overrun & prev_ovr, 0);

        if (des_start) start_cycles++;
        if (prev_start && !des_start && !reset) xfers++;
        if (frame_err) ferr_pulses++;
        if (overrun) ovr_pulses++;
        prev_start = des_start;
        prev_ferr  = frame_err;
        prev_ovr   = overrun;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        #2 rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        #2 rx_valid = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [63:0] k,
                              input logic [63:0] d, input int max_gap);
        send_byte(cmd);
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, max_gap));
            send_byte(k[63 - 8*i -: 8]);
        end
        for (int i = 0; i < 8; i++) begin
            idle($urandom_range(0, max_gap));
            send_byte(d[63 - 8*i -: 8]);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            #2 des_ready = 1'b1;
            n++;
        end
        check("wait_idle_bound", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, des_start, 0);
        check({tag, "_dec"}, des_decrypt, 0);
        check({tag, "_key"}, des_key, 0);
        check({tag, "_block"}, des_block, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ferr"}, frame_err, 0);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
    localparam logic [63:0] B1 = 64'h0123456789ABCDEF;

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, required finish before 900000");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, x0, f0, o0;
        logic [63:0] k, d;
        logic [7:0]  b;
        reset = 1'b1; rx_valid = 1'b0; rx_data = '0; des_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("por");
        #1 reset = 1'b0;

        // Encrypt with the standard test vector, ready already high.
        des_ready = 1'b1;
        s0 = start_cycles; x0 = xfers;
        send_frame(8'h45, K1, B1, 0);
        #1 check("t1_start", des_start, 1);
        check("t1_key", des_key, K1);
        check("t1_block", des_block, B1);
        check("t1_dec", des_decrypt, 0);
        @(negedge clk);
        #1 check("t1_start_low", des_start, 0);
        check("t1_busy", busy, 0);
        check("t1_start_cycles", start_cycles - s0, 1);
        check("t1_xfers", xfers - x0, 1);

        // Decrypt held off by des_ready=0 for 50 cycles.
        des_ready = 1'b0;
        k = {$urandom, $urandom}; d = {$urandom, $urandom};
        s0 = start_cycles; x0 = xfers;
        send_frame(8'h44, k, d, 1);
        idle(50);
        #1 check("t2_start_held", des_start, 1);
        check("t2_dec", des_decrypt, 1);
        check("t2_key", des_key, k);
        check("t2_block", des_block, d);
        #1 des_ready = 1'b1;
        wait_idle();
        check("t2_held_50", (start_cycles - s0) >= 50 ? 1 : 0, 1);
        check("t2_xfers", xfers - x0, 1);

        // Bad command byte, then a good frame.
        f0 = ferr_pulses;
        send_byte(8'h7A);
        idle(2);
        check("t3_ferr", ferr_pulses - f0, 1);
        check("t3_busy", busy, 0);
        send_frame(8'h45, K1, B1, 2);
        #1 check("t3_key", des_key, K1);
        check("t3_block", des_block, B1);
        wait_idle();

        // Timeout after 3 key bytes, then a good frame.
        f0 = ferr_pulses;
        send_byte(8'h45);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        idle(101);
        check("t4_ferr", ferr_pulses - f0, 1);
        check("t4_busy", busy, 0);
        k = {$urandom, $urandom}; d = {$urandom, $urandom};
        send_frame(8'h44, k, d, 0);
        #1 check("t4_key", des_key, k);
        check("t4_block", des_block, d);
        wait_idle();

        // Byte landing on the limit cycle is accepted; one cycle later times out.
        f0 = ferr_pulses;
        send_byte(8'h45);
        send_byte(8'h11);
        idle(98);
        send_byte(8'h22);
        check("t5_no_tmo", ferr_pulses - f0, 0);
        check("t5_busy", busy, 1);
        idle(101);
        check("t5_tmo", ferr_pulses - f0, 1);
        check("t5_idle", busy, 0);

        // Overrun while waiting in ISSUE.
        des_ready = 1'b0;
        k = {$urandom, $urandom}; d = {$urandom, $urandom};
        send_frame(8'h45, k, d, 0);
        o0 = ovr_pulses;
        send_byte(8'hFF);
        check("t6_ovr", ovr_pulses - o0, 1);
        check("t6_block", des_block, d);
        check("t6_start", des_start, 1);
        wait_idle();

        // Reset after 10 bytes abandons the frame.
        s0 = start_cycles;
        send_byte(8'h45);
        for (int i = 0; i < 9; i++) send_byte(8'($urandom));
        #1 reset = 1'b1;
        #1 check_reset_outputs("mid");
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        idle(20);
        check("t7_no_start", start_cycles - s0, 0);
        send_frame(8'h45, K1, B1, 0);
        #1 check("t7_key", des_key, K1);
        check("t7_block", des_block, B1);
        wait_idle();

        // Randomized mix of frames, errors, timeouts and overruns.
        for (int it = 0; it < 30; it++) begin
            int kind;
            kind = $urandom_range(0, 4);
            des_ready = 1'($urandom_range(0, 1));
            k = {$urandom, $urandom}; d = {$urandom, $urandom};
            case (kind)
                0: begin
                    b = 8'($urandom);
                    if (b == 8'h44 || b == 8'h45) b = 8'h7A;
                    send_byte(b);
                end
                3: begin
                    send_byte(($urandom_range(0, 1) != 0) ? 8'h44 : 8'h45);
                    for (int i = 0; i < $urandom_range(0, 15); i++) send_byte(8'($urandom));
                    idle(TMO + 1 + $urandom_range(0, 5));
                end
                4: begin
                    des_ready = 1'b0;
                    send_frame(8'h45, k, d, 2);
                    send_byte(8'($urandom));
                end
                default: begin
                    send_frame(($urandom_range(0, 1) != 0) ? 8'h44 : 8'h45, k, d,
                               ($urandom_range(0, 9) == 0) ? 98 : 3);
                end
            endcase
            for (int i = 0; i < $urandom_range(0, 15); i++) begin
                @(negedge clk);
                #2 des_ready = 1'($urandom_range(0, 1));
            end
            wait_idle();
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_frame_assembler.md
DES_FRAME_ASSEMBLER -- requirements
Module: des_frame_assembler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, meaning the maximum idle clocks allowed between bytes within a frame (10 ms at 100 MHz).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-005 The block SHALL have port rx_valid  input  1  single-cycle strobe marking rx_data valid.
REQ-006 The block SHALL have port des_ready  input  1  DES core able to accept a job.
REQ-007 The block SHALL have port des_start  output  1  job valid; held high until accepted.
REQ-008 The block SHALL have port des_decrypt  output  1  job mode: 1 = decrypt, 0 = encrypt.
REQ-009 The block SHALL have port des_key  output  64  assembled key.
REQ-010 The block SHALL have port des_block  output  64  assembled data block.
REQ-011 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port frame_err  output  1  one-cycle pulse on bad command byte or timeout.
REQ-013 The block SHALL have port overrun  output  1  one-cycle pulse when a byte arrives in ISSUE and is dropped.

Function
REQ-014 The frame format SHALL be 17 bytes in this order: 1 command byte, 8 key bytes, 8 data bytes.
REQ-015 The command byte SHALL be 0x45 ('E') for encrypt or 0x44 ('D') for decrypt.
REQ-016 The FSM SHALL have states IDLE, KEY, DATA and ISSUE, and SHALL advance only on cycles with rx_valid=1, except for the ISSUE handshake and the timeout.
REQ-017 IDLE with a valid 0x45/0x44 byte: the block SHALL latch des_decrypt (0x44 -> 1), clear the byte counter and go to KEY.
REQ-018 IDLE with any other valid byte: the block SHALL pulse frame_err for one cycle and stay in IDLE.
REQ-019 KEY and DATA SHALL assemble bytes big-endian: the first byte goes to bits [63:56] and the eighth byte to bits [7:0], via a left shift by 8 per byte.
REQ-020 The byte counter SHALL be 3 bits; on the byte that wraps it from 7 to 0, KEY SHALL go to DATA and DATA SHALL go to ISSUE.
REQ-021 The transition into ISSUE SHALL assert des_start on the next cycle, i.e. 1 clock after the 17th rx_valid.
REQ-022 In ISSUE, des_start SHALL stay high until a cycle with des_start=1 and des_ready=1; the FSM SHALL then go to IDLE with des_start=0 on the following cycle.
REQ-023 des_key, des_block and des_decrypt SHALL be stable while des_start=1.
REQ-024 If des_ready is already high when ISSUE is entered, the transfer SHALL complete with des_start high for exactly 1 cycle.
REQ-025 rx_valid during ISSUE SHALL drop the byte and pulse overrun; the state and data registers SHALL be unchanged.
REQ-026 A 32-bit timeout counter SHALL clear on every rx_valid and on entry to KEY, and SHALL increment each cycle in KEY or DATA.
REQ-027 When the timeout counter reaches TIMEOUT_CYCLES-1 with rx_valid=0, the block SHALL pulse frame_err, go to IDLE and discard the partial frame.
REQ-028 If rx_valid coincides with the cycle the timeout limit is reached, the byte SHALL be accepted and no timeout SHALL occur.
REQ-029 The timeout SHALL NOT apply in IDLE or ISSUE; ISSUE may wait on des_ready indefinitely.
REQ-030 frame_err and overrun SHALL never be high for more than one consecutive cycle per event.
REQ-031 busy SHALL be a registered decode of state != IDLE.

Reset
REQ-032 On reset assertion, independent of clk, the block SHALL set state to IDLE and all counters to 0.
REQ-033 On reset assertion, the block SHALL drive des_start=0, des_decrypt=0, des_key=0, des_block=0, busy=0, frame_err=0 and overrun=0.
REQ-034 Reset asserted mid-frame or in ISSUE SHALL abandon the job with no des_start.
REQ-035 After reset deassertion, the first accepted byte SHALL be treated as a command byte.

Verification
REQ-036 The bench SHALL drive 0x45, key 13 34 57 79 9B BC DF F1, data 01 23 45 67 89 AB CD EF with des_ready=1 -> required response: des_start pulses 1 cycle, des_decrypt=0, des_key=0x133457799BBCDFF1, des_block=0x0123456789ABCDEF.
REQ-037 The bench SHALL drive 0x44 plus 16 bytes with des_ready=0 for 50 cycles, then 1 -> required response: des_start held 50+ cycles with outputs stable; one transfer; busy falls after acceptance; des_decrypt=1.
REQ-038 The bench SHALL drive 0x7A in IDLE -> required response: frame_err 1-cycle pulse; a following valid frame is assembled correctly.
REQ-039 With TIMEOUT_CYCLES=100, the bench SHALL drive 0x45 and 3 key bytes, then stall 100 cycles -> required response: frame_err pulse, state IDLE; a following full frame produces correct outputs.
REQ-040 The bench SHALL hold des_ready=0 in ISSUE and inject byte 0xFF -> required response: overrun pulse; des_block unchanged.
REQ-041 The bench SHALL assert reset after 10 bytes of a frame -> required response: all outputs 0 immediately; no des_start; the next full frame is correct.
